// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the conditioner.
// The master side drives raw pins; the slave side (the conditioner) drives the clean outputs.
interface button_conditioner_if #(
  parameter int unsigned NUM_BTN = 5
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_repeat;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-button synchronizer, debouncer and auto-repeat strobe generator.
// Every channel has its own counters, so channels never interact.
module button_conditioner #(
  parameter int unsigned NUM_BTN       = 5,
  parameter int unsigned DB_CYCLES     = 1000000,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input logic                 clk,
  input logic                 rst_n,
  button_conditioner_if.slave btn_if
);

  localparam int unsigned DbW    = $clog2(DB_CYCLES + 1);
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  // The repeat counter only ever holds values up to RepMax-1.
  localparam int unsigned RepW   = (RepMax < 2) ? 1 : $clog2(RepMax);

  localparam logic [DbW-1:0]  DbLast     = DbW'(DB_CYCLES - 1);
  localparam logic [RepW-1:0] DelayLast  = RepW'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] PeriodLast = RepW'((REPEAT_PERIOD == 0) ? 0 : REPEAT_PERIOD - 1);

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] rel_q, rel_d;
  logic [NUM_BTN-1:0] repeat_q, repeat_d;
  logic [NUM_BTN-1:0] first_q, first_d;
  logic [DbW-1:0]     db_cnt_q  [NUM_BTN];
  logic [DbW-1:0]     db_cnt_d  [NUM_BTN];
  logic [RepW-1:0]    rep_cnt_q [NUM_BTN];
  logic [RepW-1:0]    rep_cnt_d [NUM_BTN];

  // Debounce and repeat next-state for every channel.
  always_comb begin
    level_d  = level_q;
    press_d  = '0;
    rel_d    = '0;
    repeat_d = '0;
    first_d  = first_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      db_cnt_d[i]  = '0;
      rep_cnt_d[i] = '0;

      // Count consecutive cycles the synchronized input disagrees with the accepted level.
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          level_d[i] = sync2_q[i];
          press_d[i] = sync2_q[i];
          rel_d[i]   = ~sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end

      // A release accepted this edge suppresses any repeat that would land on it.
      if (press_d[i]) begin
        repeat_d[i] = 1'b1;
        first_d[i]  = 1'b1;
      end else if (rel_d[i] || !level_q[i] || (REPEAT_DELAY == 0)) begin
        first_d[i] = 1'b0;
      end else if (first_q[i] && (rep_cnt_q[i] == DelayLast)) begin
        repeat_d[i] = 1'b1;
        first_d[i]  = 1'b0;
      end else if (!first_q[i] && (rep_cnt_q[i] == PeriodLast)) begin
        repeat_d[i] = 1'b1;
      end else begin
        rep_cnt_d[i] = rep_cnt_q[i] + RepW'(1);
      end
    end
  end

  // State registers, including the two-flop synchronizer on the raw pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      repeat_q <= '0;
      first_q  <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_q[i]  <= '0;
        rep_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= btn_if.btn_raw;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      repeat_q <= repeat_d;
      first_q  <= first_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt_q[i]  <= db_cnt_d[i];
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
    end
  end

  assign btn_if.btn_level   = level_q;
  assign btn_if.btn_press   = press_q;
  assign btn_if.btn_release = rel_q;
  assign btn_if.btn_repeat  = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  button_conditioner_if #(.NUM_BTN(5)) bif ();

  button_conditioner #(
    .NUM_BTN      (5),
    .DB_CYCLES    (4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_if(bif.slave)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Observed outputs packed as {level, press, release, repeat}.
  function automatic logic [19:0] outs();
    return {bif.btn_level, bif.btn_press, bif.btn_release, bif.btn_repeat};
  endfunction

  function automatic logic [19:0] pack(input logic [4:0] l, input logic [4:0] p,
                                       input logic [4:0] r, input logic [4:0] rp);
    return {l, p, r, rp};
  endfunction

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed(lvl,prs,rel,rep)=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bif.btn_raw = '0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    logic [0:14] pat;
    logic [4:0]  e_rep;
    logic [19:0] o;

    // Reset held with all buttons pressed.
    rst_n = 1'b0;
    bif.btn_raw = 5'h1F;
    tick(3);
    chk("rst_hold", outs(), '0);
    rst_n = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick(1);
      chk("rst_wait", outs(), '0);
    end
    tick(1);
    chk("rst_press", outs(), pack(5'h1F, 5'h1F, 5'h00, 5'h1F));
    tick(1);
    chk("rst_single", outs(), pack(5'h1F, 5'h00, 5'h00, 5'h00));
    do_reset();
    tick(6);
    chk("idle", outs(), '0);

    // Bounce rejection on bit 1.
    pat = 15'b111_00_111_0000000;
    for (int i = 0; i < 15; i++) begin
      bif.btn_raw[1] = pat[i];
      tick(1);
      chk("bounce", outs(), '0);
    end
    tick(4);

    // Clean press and release on bit 0.
    bif.btn_raw[0] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      chk("clean_press", outs(), pack((e >= 6) ? 5'h01 : 5'h00, (e == 6) ? 5'h01 : 5'h00,
                                      5'h00, (e == 6) ? 5'h01 : 5'h00));
    end
    tick(19);
    bif.btn_raw[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      chk("clean_release", outs(), pack((k < 6) ? 5'h01 : 5'h00, 5'h00,
                                        (k == 6) ? 5'h01 : 5'h00,
                                        (k == 2 || k == 5) ? 5'h01 : 5'h00));
    end
    do_reset();

    // Auto-repeat on bit 2, release after 30 cycles of hold.
    bif.btn_raw[2] = 1'b1;
    tick(6);
    for (int off = 0; off <= 40; off++) begin
      e_rep = ((off == 0) || (off >= 10 && off < 36 && ((off - 10) % 3) == 0)) ? 5'h04 : 5'h00;
      chk("repeat", outs(), pack((off < 36) ? 5'h04 : 5'h00, (off == 0) ? 5'h04 : 5'h00,
                                 (off == 36) ? 5'h04 : 5'h00, e_rep));
      if (off == 30) bif.btn_raw[2] = 1'b0;
      tick(1);
    end
    do_reset();

    // Reset asserted mid-hold on bit 3.
    bif.btn_raw[3] = 1'b1;
    tick(6);
    chk("mid_press", outs(), pack(5'h08, 5'h08, 5'h00, 5'h08));
    tick(12);
    chk("mid_hold", outs(), pack(5'h08, 5'h00, 5'h00, 5'h00));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_now", outs(), '0);
    tick(2);
    chk("mid_rst_hold", outs(), '0);
    rst_n = 1'b1;
    tick(5);
    chk("mid_rst_wait", outs(), '0);
    tick(1);
    chk("mid_repress", outs(), pack(5'h08, 5'h08, 5'h00, 5'h08));
    tick(1);
    chk("mid_repress_1cyc", outs(), pack(5'h08, 5'h00, 5'h00, 5'h00));
    do_reset();

    // Simultaneous press on bits 0 and 4, then a short bounce on bit 4.
    bif.btn_raw = 5'h11;
    tick(5);
    chk("simul_wait", outs(), '0);
    tick(1);
    chk("simul_press", outs(), pack(5'h11, 5'h11, 5'h00, 5'h11));
    tick(3);
    bif.btn_raw[4] = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (j == 2) bif.btn_raw[4] = 1'b1;
      tick(1);
      o = outs();
      o[4:0] = 5'h00;
      chk("simul_bounce", o, pack(5'h11, 5'h00, 5'h00, 5'h00));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
